// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects the result source, aligns and extends load data, and
// registers the register-file write port, the misaligned-load pulse and the retire count.
module wb_stage_pipe #(
  parameter  int DATA_W     = 32,
  parameter  int REG_ADDR_W = 5,
  parameter  int CNT_W      = 32,
  localparam int OFF_W      = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [1:0]            wb_sel,
  input  logic                  is_memRead,
  input  logic                  is_memWrite,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [2:0]            funct3,
  input  logic [OFF_W-1:0]      addr_lsb,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     imm,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  misalign_err,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // Shift the addressed lane down to bit 0, then size/sign it by funct3.
  // Code 111 bypasses the lane shift and returns the raw bus word.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                    input logic [2:0]        f3,
                                                    input logic [OFF_W-1:0]  off);
    logic [DATA_W-1:0] lane;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;
    logic [DATA_W-1:0]  res;
    lane   = raw >> {off, 3'b000};
    byte_s = lane[7:0];
    half_s = lane[15:0];
    word_s = lane[31:0];
    res    = lane;
    case (f3)
      3'b000:  res = DATA_W'(byte_s);
      3'b001:  res = DATA_W'(half_s);
      3'b010:  res = DATA_W'(word_s);
      3'b100:  res = DATA_W'(lane[7:0]);
      3'b101:  res = DATA_W'(lane[15:0]);
      3'b110:  res = DATA_W'(lane[31:0]);
      3'b011:  res = (DATA_W == 64) ? lane : DATA_W'(word_s);
      default: res = raw;
    endcase
    return res;
  endfunction

  // On a 32-bit datapath LD degenerates to LW, so its alignment rule matches too.
  function automatic logic is_misaligned(input logic [2:0]       f3,
                                         input logic [OFF_W-1:0] off);
    logic half_acc;
    logic word_acc;
    logic dbl_acc;
    half_acc = (f3[1:0] == 2'b01);
    word_acc = (f3[1:0] == 2'b10);
    dbl_acc  = (f3 == 3'b011);
    return (half_acc && off[0]) ||
           (word_acc && (off[1:0] != 2'b00)) ||
           (dbl_acc  && (off != '0));
  endfunction

  // Stage 0: acceptance, result select and write qualification (combinational)
  logic              vld_p0;
  logic              mis_p0;
  logic              we_p0;
  logic [DATA_W-1:0] wdata_p0;

  assign in_ready = !stall;
  assign vld_p0   = in_valid && !stall && !flush;
  assign mis_p0   = (wb_sel == SEL_MEM) && is_memRead && is_misaligned(funct3, addr_lsb);
  assign we_p0    = reg_write && !is_memWrite && (rd != '0) && !mis_p0;

  always_comb begin
    wdata_p0 = alu_data;
    case (wb_sel)
      SEL_ALU: wdata_p0 = alu_data;
      SEL_MEM: wdata_p0 = load_extend(mem_data, funct3, addr_lsb);
      SEL_PC4: wdata_p0 = pc_plus4;
      SEL_IMM: wdata_p0 = imm;
      default: wdata_p0 = alu_data;
    endcase
  end

  // Stage 1: registered write port, error pulse and retire counter
  logic                  we_p1;
  logic                  mis_p1;
  logic [REG_ADDR_W-1:0] waddr_p1;
  logic [DATA_W-1:0]     wdata_p1;
  logic [CNT_W-1:0]      cnt_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_p1    <= 1'b0;
      mis_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      cnt_p1   <= '0;
    end else begin
      we_p1  <= vld_p0 && we_p0;
      mis_p1 <= vld_p0 && mis_p0;
      if (vld_p0) begin
        waddr_p1 <= rd;
        wdata_p1 <= wdata_p0;
      end
      // Stores and rd=0 entries retire; only misaligned loads do not.
      if (vld_p0 && !mis_p0) begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

  assign rf_we        = we_p1;
  assign misalign_err = mis_p1;
  assign rf_waddr     = waddr_p1;
  assign rf_wdata     = wdata_p1;
  assign retire_cnt   = cnt_p1;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed bench for wb_stage_pipe: vector table for single-entry behaviour plus
// hand-written sequences for stall, flush, counter wrap and asynchronous reset.
module tb_wb_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, stall, flush;
  logic [1:0]    wb_sel;
  logic          is_memRead, is_memWrite, reg_write;
  logic [AW-1:0] rd;
  logic [2:0]    funct3;
  logic [1:0]    addr_lsb;
  logic [DW-1:0] alu_data, mem_data, pc_plus4, imm;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          misalign_err;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  wb_stage_pipe #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .wb_sel(wb_sel), .is_memRead(is_memRead),
    .is_memWrite(is_memWrite), .reg_write(reg_write), .rd(rd), .funct3(funct3),
    .addr_lsb(addr_lsb), .alu_data(alu_data), .mem_data(mem_data),
    .pc_plus4(pc_plus4), .imm(imm), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .misalign_err(misalign_err), .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        mrd, mwr, rw;
    logic [4:0]  rd;
    logic [31:0] alu, mem, pc4, imm;
    logic        exp_we;
    logic [31:0] exp_wd;
    logic        exp_mis;
    logic        exp_inc;
  } vec_t;

  localparam int NV = 18;
  vec_t vt[NV];

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW-1:0] exp_cnt;

  function automatic vec_t mk(logic [1:0] sel, logic [2:0] f3, logic [1:0] off,
                              logic mrd, logic mwr, logic rw, logic [4:0] rdv,
                              logic [31:0] alu, logic [31:0] mem, logic [31:0] pc4,
                              logic [31:0] immv, logic we, logic [31:0] wd,
                              logic mis, logic inc);
    vec_t v;
    v.sel = sel; v.f3 = f3; v.off = off; v.mrd = mrd; v.mwr = mwr; v.rw = rw;
    v.rd = rdv; v.alu = alu; v.mem = mem; v.pc4 = pc4; v.imm = immv;
    v.exp_we = we; v.exp_wd = wd; v.exp_mis = mis; v.exp_inc = inc;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; wb_sel = 2'b00;
    is_memRead = 1'b0; is_memWrite = 1'b0; reg_write = 1'b0; rd = '0;
    funct3 = 3'b000; addr_lsb = 2'b00; alu_data = '0; mem_data = '0;
    pc_plus4 = '0; imm = '0;
  endtask

  task automatic drive(vec_t v);
    in_valid = 1'b1; wb_sel = v.sel; funct3 = v.f3; addr_lsb = v.off;
    is_memRead = v.mrd; is_memWrite = v.mwr; reg_write = v.rw; rd = v.rd;
    alu_data = v.alu; mem_data = v.mem; pc_plus4 = v.pc4; imm = v.imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_we"},    64'(rf_we),        64'd0);
    chk({tag, "_waddr"}, 64'(rf_waddr),     64'd0);
    chk({tag, "_wdata"}, 64'(rf_wdata),     64'd0);
    chk({tag, "_mis"},   64'(misalign_err), 64'd0);
    chk({tag, "_cnt"},   64'(retire_cnt),   64'd0);
  endtask

  localparam logic [31:0] MD = 32'h80FF7F01;

  initial begin
    //         sel    f3     off    mrd  mwr  rw   rd     alu           mem  pc4           imm           we   wdata         mis  inc
    vt[0]  = mk(2'b00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 5'd5,  32'h12345678, MD, 32'h0,        32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1);
    vt[1]  = mk(2'b01, 3'b000, 2'd3, 1'b1, 1'b0, 1'b1, 5'd6,  32'h0,        MD, 32'h0,        32'h0,        1'b1, 32'hFFFFFF80, 1'b0, 1'b1);
    vt[2]  = mk(2'b01, 3'b100, 2'd2, 1'b1, 1'b0, 1'b1, 5'd7,  32'h0,        MD, 32'h0,        32'h0,        1'b1, 32'h000000FF, 1'b0, 1'b1);
    vt[3]  = mk(2'b01, 3'b001, 2'd2, 1'b1, 1'b0, 1'b1, 5'd8,  32'h0,        MD, 32'h0,        32'h0,        1'b1, 32'hFFFF80FF, 1'b0, 1'b1);
    vt[4]  = mk(2'b01, 3'b101, 2'd0, 1'b1, 1'b0, 1'b1, 5'd9,  32'h0,        MD, 32'h0,        32'h0,        1'b1, 32'h00007F01, 1'b0, 1'b1);
    vt[5]  = mk(2'b01, 3'b010, 2'd0, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0,        MD, 32'h0,        32'h0,        1'b1, 32'h80FF7F01, 1'b0, 1'b1);
    vt[6]  = mk(2'b01, 3'b111, 2'd1, 1'b1, 1'b0, 1'b1, 5'd11, 32'h0,        MD, 32'h0,        32'h0,        1'b1, 32'h80FF7F01, 1'b0, 1'b1);
    vt[7]  = mk(2'b10, 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 5'd1,  32'h0,        MD, 32'h00001004, 32'h0,        1'b1, 32'h00001004, 1'b0, 1'b1);
    vt[8]  = mk(2'b11, 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 5'd31, 32'h0,        MD, 32'h0,        32'hFFFFF800, 1'b1, 32'hFFFFF800, 1'b0, 1'b1);
    vt[9]  = mk(2'b00, 3'b010, 2'd0, 1'b0, 1'b1, 1'b1, 5'd12, 32'h0000AAAA, MD, 32'h0,        32'h0,        1'b0, 32'h0000AAAA, 1'b0, 1'b1);
    vt[10] = mk(2'b00, 3'b000, 2'd0, 1'b0, 1'b0, 1'b1, 5'd0,  32'h00000011, MD, 32'h0,        32'h0,        1'b0, 32'h00000011, 1'b0, 1'b1);
    vt[11] = mk(2'b01, 3'b010, 2'd1, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0,        MD, 32'h0,        32'h0,        1'b0, 32'h0080FF7F, 1'b1, 1'b0);
    vt[12] = mk(2'b01, 3'b001, 2'd1, 1'b1, 1'b0, 1'b1, 5'd14, 32'h0,        MD, 32'h0,        32'h0,        1'b0, 32'hFFFFFF7F, 1'b1, 1'b0);
    vt[13] = mk(2'b01, 3'b101, 2'd3, 1'b1, 1'b0, 1'b1, 5'd15, 32'h0,        MD, 32'h0,        32'h0,        1'b0, 32'h00000080, 1'b1, 1'b0);
    vt[14] = mk(2'b01, 3'b010, 2'd1, 1'b0, 1'b0, 1'b1, 5'd16, 32'h0,        MD, 32'h0,        32'h0,        1'b1, 32'h0080FF7F, 1'b0, 1'b1);
    vt[15] = mk(2'b01, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 5'd17, 32'h0,        MD, 32'h0,        32'h0,        1'b0, 32'h00000001, 1'b0, 1'b1);
    vt[16] = mk(2'b01, 3'b011, 2'd0, 1'b1, 1'b0, 1'b1, 5'd18, 32'h0,        MD, 32'h0,        32'h0,        1'b1, 32'h80FF7F01, 1'b0, 1'b1);
    vt[17] = mk(2'b00, 3'b010, 2'd1, 1'b1, 1'b0, 1'b1, 5'd19, 32'h00000005, MD, 32'h0,        32'h0,        1'b1, 32'h00000005, 1'b0, 1'b1);

    idle();
    rst = 1'b1;
    #3;
    chk_zero("reset");
    tick();
    rst = 1'b0;
    exp_cnt = '0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i]);
      if (i == 0) begin
        #1;
        chk("vec_in_ready", 64'(in_ready), 64'd1);
      end
      tick();
      exp_cnt = exp_cnt + CW'(vt[i].exp_inc);
      chk($sformatf("vec%0d_we", i),    64'(rf_we),        64'(vt[i].exp_we));
      chk($sformatf("vec%0d_waddr", i), 64'(rf_waddr),     64'(vt[i].rd));
      chk($sformatf("vec%0d_wdata", i), 64'(rf_wdata),     64'(vt[i].exp_wd));
      chk($sformatf("vec%0d_mis", i),   64'(misalign_err), 64'(vt[i].exp_mis));
      chk($sformatf("vec%0d_cnt", i),   64'(retire_cnt),   64'(exp_cnt));
    end

    // idle cycle: strobes drop, write port holds the last entry
    idle();
    tick();
    chk("idle_we",    64'(rf_we),        64'd0);
    chk("idle_mis",   64'(misalign_err), 64'd0);
    chk("idle_cnt",   64'(retire_cnt),   64'(exp_cnt));
    chk("idle_waddr", 64'(rf_waddr),     64'd19);
    chk("idle_wdata", 64'(rf_wdata),     64'h5);

    // misaligned pulse lasts exactly one cycle
    drive(vt[11]);
    tick();
    chk("mispulse_hi", 64'(misalign_err), 64'd1);
    idle();
    tick();
    chk("mispulse_lo",  64'(misalign_err), 64'd0);
    chk("mispulse_cnt", 64'(retire_cnt),   64'(exp_cnt));

    // stall held for three cycles with a valid entry waiting
    drive(vt[0]);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall%0d_ready", c), 64'(in_ready),   64'd0);
      chk($sformatf("stall%0d_we", c),    64'(rf_we),      64'd0);
      chk($sformatf("stall%0d_cnt", c),   64'(retire_cnt), 64'(exp_cnt));
    end
    stall = 1'b0;
    #1;
    chk("unstall_ready", 64'(in_ready), 64'd1);
    tick();
    exp_cnt = exp_cnt + CW'(1);
    chk("unstall_we",  64'(rf_we),      64'd1);
    chk("unstall_cnt", 64'(retire_cnt), 64'(exp_cnt));

    // flush squashes a valid entry; flush wins over stall
    drive(vt[7]);
    flush = 1'b1;
    tick();
    chk("flush_we",    64'(rf_we),      64'd0);
    chk("flush_cnt",   64'(retire_cnt), 64'(exp_cnt));
    chk("flush_wdata", 64'(rf_wdata),   64'h12345678);
    stall = 1'b1;
    #1;
    chk("flushstall_ready", 64'(in_ready), 64'd0);
    tick();
    chk("flushstall_we",  64'(rf_we),      64'd0);
    chk("flushstall_cnt", 64'(retire_cnt), 64'(exp_cnt));
    stall = 1'b0;
    drive(vt[11]);
    flush = 1'b1;
    tick();
    chk("flushmis_mis", 64'(misalign_err), 64'd0);
    flush = 1'b0;

    // counter wrap: 16 retirements from reset return to zero
    idle();
    rst = 1'b1;
    #1;
    chk("rst2_cnt", 64'(retire_cnt), 64'd0);
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    drive(vt[0]);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_cnt = exp_cnt + CW'(1);
      if (k == 15 || k == 16)
        chk($sformatf("wrap%0d_cnt", k), 64'(retire_cnt), 64'(exp_cnt));
    end
    chk("wrap_zero", 64'(retire_cnt), 64'd0);

    // asynchronous reset in the middle of a stream
    tick();
    chk("midrst_pre_we", 64'(rf_we), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst_async");
    tick();
    chk_zero("midrst_held");
    rst = 1'b0;
    tick();
    chk("postrst_we",    64'(rf_we),      64'd1);
    chk("postrst_waddr", 64'(rf_waddr),   64'd5);
    chk("postrst_wdata", 64'(rf_wdata),   64'h12345678);
    chk("postrst_cnt",   64'(retire_cnt), 64'd1);

    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
